instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter MAX_WORDS, default 1024, SHALL be the number of words written before the block reports full.
REQ-002 Ports SHALL be exactly as follows (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; loads base_addr, clears count and err
- base_addr  in  32  first memory byte address
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_class  in  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 MUL, 5 DIV, 6 LDR, 7 STR, 8 B, 9 UMULL, 10 SMULL, 11-15 illegal
- in_cond  in  4  condition field
- in_s  in  1  set-flags bit
- in_use_imm  in  1  data-processing immediate operand
- in_rd  in  4  Rd, or RdLo for long multiply
- in_ra  in  4  RdHi for long multiply
- in_rn  in  4  Rn
- in_rm  in  4  Rm
- in_imm  in  32  immediate or signed branch word offset
- mem_we  out  1  write request, held until accepted
- mem_addr  out  32  write byte address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  write accepted when mem_we & mem_ready
- word_count  out  16  words written since start
- full  out  1  word_count == MAX_WORDS
- err  out  1  sticky encoding error

Function
REQ-003 Encoding SHALL place cond in [31:28], Op in [27:26], Funct in [25:20] (I, cmd[3:0], S), Rn in [19:16], Rd in [15:12].
REQ-004 ADD/SUB/AND/ORR/MUL/DIV SHALL use Op=00 with cmd 0100/0010/0000/1100/1001/0001; I=in_use_imm; if I=1, [11:0]={0000,imm[7:0]}; if I=0, [11:0]={8'h00,Rm}.
REQ-005 MUL and DIV SHALL always encode I=0, even when in_use_imm=1.
REQ-006 LDR/STR SHALL use Op=01, bits[25:20]=0,1,1,0,0,L (L=1 LDR), [11:0]=imm[11:0].
REQ-007 B SHALL use Op=10, bits[25:24]=10, [23:0]=imm[23:0].
REQ-008 UMULL/SMULL SHALL encode [27:23]=00001, [22]=U (1 UMULL, 0 SMULL), [21]=0, [20]=S, [19:16]=in_ra, [15:12]=in_rd, [11:8]=Rm, [7:4]=1001, [3:0]=Rn.
REQ-009 An encoding error SHALL occur for an illegal class, a DP immediate above 255, a MEM immediate above 4095, or a B offset outside the signed range -2^23..2^23-1.
REQ-010 FSM states SHALL be IDLE, WRITE, and ERR.
REQ-011 in_ready SHALL be 1 only in IDLE with full=0 and start=0.
REQ-012 On acceptance in IDLE, the FSM SHALL go to WRITE with mem_wdata registered, or to ERR on an encoding error.
REQ-013 mem_we SHALL assert on the cycle after acceptance (latency 1).
REQ-014 In WRITE, mem_we, mem_addr and mem_wdata SHALL hold stable until mem_ready=1.
REQ-015 On write acceptance, mem_addr SHALL increment by 4 (wrapping modulo 2^32), word_count SHALL increment, and the FSM SHALL return to IDLE.
REQ-016 ERR SHALL set err, perform no write and no increment, and remain in ERR until start or reset.
REQ-017 start SHALL have priority over all other inputs.
REQ-018 start in WRITE SHALL abort the pending word, with mem_we=0 on the next cycle.
REQ-019 start SHALL load mem_addr=base_addr, clear word_count and err, and enter IDLE.
REQ-020 When word_count reaches MAX_WORDS, full SHALL be 1 and in_ready 0 until start.

Reset
REQ-021 Reset SHALL force IDLE, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, err=0, full=0.
REQ-022 in_ready SHALL be 0 during the reset cycle.
REQ-023 Reset mid-WRITE SHALL discard the pending word.

Structure
REQ-024 A shared package SHALL hold the in_class enumeration, the Op codes (00/01/10), the cmd codes, the long-multiply pattern constants (00001, 1001), and the FSM state type.
REQ-025 A combinational sub-module instr_encode_word SHALL map descriptor fields to {word, illegal}, so the checker can reuse it as a reference model.

Verification
REQ-026 After start with base_addr=0x100: ADD cond=E, Rd=1, Rn=2, imm=5, use_imm=1, S=0 -> mem_wdata=0xE2821005 at mem_addr=0x100; word_count=1.
REQ-027 LDR Rd=3, Rn=4, imm=8, followed by STR with the same fields -> 0xE5943008 at 0x104, then 0xE5843008 at 0x108.
REQ-028 B cond=E, imm=-2 -> 0xEAFFFFFE; UMULL RdLo=0, RdHi=1, Rn=2, Rm=3 -> 0xE0C10392; SMULL with the same fields -> 0xE0810392.
REQ-029 mem_ready held 0 for 5 cycles -> mem_we and mem_wdata remain stable for all 5 cycles, in_ready=0 throughout, and exactly one write occurs.
REQ-030 ADD with imm=256 -> err=1, no mem_we, and in_ready=0; a subsequent start -> err=0 and in_ready=1.
REQ-031 With MAX_WORDS=2, after two writes -> full=1 and in_ready=0; start asserted during a pending WRITE -> mem_we=0 on the next cycle and word_count=0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared types and field constants for the instruction encoder
// Contents: instruction class enum, Op codes, data-processing cmd codes,
//           long-multiply pattern constants, immediate limits, FSM state type.
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        CLS_ADD   = 4'd0,
        CLS_SUB   = 4'd1,
        CLS_AND   = 4'd2,
        CLS_ORR   = 4'd3,
        CLS_MUL   = 4'd4,
        CLS_DIV   = 4'd5,
        CLS_LDR   = 4'd6,
        CLS_STR   = 4'd7,
        CLS_B     = 4'd8,
        CLS_UMULL = 4'd9,
        CLS_SMULL = 4'd10
    } instr_class_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MUL = 4'b1001;
    localparam logic [3:0] CMD_DIV = 4'b0001;

    // Long multiply: bits [27:23] and bits [7:4]
    localparam logic [4:0] LMUL_HI   = 5'b00001;
    localparam logic [3:0] LMUL_MARK = 4'b1001;

    localparam logic [31:0] DP_IMM_MAX  = 32'd255;
    localparam logic [31:0] MEM_IMM_MAX = 32'd4095;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encoder_word.sv
// rtl/instr_encoder_word.sv - combinational descriptor-to-instruction-word encoder
// Ports: cls/cond/s/use_imm/rd/ra/rn/rm/imm descriptor fields in;
//        word = encoded 32-bit instruction, illegal = descriptor cannot be encoded.
module instr_encode_word
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [3:0]  cond,
    input  logic        s,
    input  logic        use_imm,
    input  logic [3:0]  rd,
    input  logic [3:0]  ra,
    input  logic [3:0]  rn,
    input  logic [3:0]  rm,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic       is_dp;
    logic       is_mem;
    logic       is_br;
    logic       is_lmul;
    logic       no_imm;     // MUL/DIV never take an immediate operand
    logic       imm_on;
    logic [3:0] cmd;

    always_comb begin
        is_dp   = 1'b0;
        is_mem  = 1'b0;
        is_br   = 1'b0;
        is_lmul = 1'b0;
        no_imm  = 1'b0;
        cmd     = CMD_AND;
        case (instr_class_e'(cls))
            CLS_ADD:   begin is_dp = 1'b1; cmd = CMD_ADD; end
            CLS_SUB:   begin is_dp = 1'b1; cmd = CMD_SUB; end
            CLS_AND:   begin is_dp = 1'b1; cmd = CMD_AND; end
            CLS_ORR:   begin is_dp = 1'b1; cmd = CMD_ORR; end
            CLS_MUL:   begin is_dp = 1'b1; cmd = CMD_MUL; no_imm = 1'b1; end
            CLS_DIV:   begin is_dp = 1'b1; cmd = CMD_DIV; no_imm = 1'b1; end
            CLS_LDR,
            CLS_STR:   is_mem  = 1'b1;
            CLS_B:     is_br   = 1'b1;
            CLS_UMULL,
            CLS_SMULL: is_lmul = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        imm_on  = use_imm & ~no_imm;
        if (is_dp) begin
            word    = {cond, OP_DP, imm_on, cmd, s, rn, rd,
                       imm_on ? {4'h0, imm[7:0]} : {8'h00, rm}};
            illegal = imm_on && (imm > DP_IMM_MAX);
        end else if (is_mem) begin
            // I=0, P=1, U=1, B=0, W=0, L
            word    = {cond, OP_MEM, 5'b01100, (cls == CLS_LDR), rn, rd, imm[11:0]};
            illegal = imm > MEM_IMM_MAX;
        end else if (is_br) begin
            word    = {cond, OP_BR, 2'b10, imm[23:0]};
            // Offset fits in 24 signed bits only if bits [31:23] are a sign extension
            illegal = (imm[31:23] != 9'h000) && (imm[31:23] != 9'h1FF);
        end else if (is_lmul) begin
            word    = {cond, LMUL_HI, (cls == CLS_UMULL), 1'b0, s, ra, rd, rm, LMUL_MARK, rn};
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - accepts instruction descriptors, encodes and writes them to memory
// Ports: clk/reset; start+base_addr restart the stream; in_* descriptor handshake;
//        mem_we/mem_addr/mem_wdata/mem_ready write handshake; word_count/full/err status.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int MAX_WORDS = 1024
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_class,
    input  logic [3:0]  in_cond,
    input  logic        in_s,
    input  logic        in_use_imm,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_ra,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rm,
    input  logic [31:0] in_imm,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic [15:0] word_count,
    output logic        full,
    output logic        err
);

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] count_q, count_d;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        accept;

    instr_encode_word u_encode (
        .cls     (in_class),
        .cond    (in_cond),
        .s       (in_s),
        .use_imm (in_use_imm),
        .rd      (in_rd),
        .ra      (in_ra),
        .rn      (in_rn),
        .rm      (in_rm),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign full     = (count_q == MAX_COUNT);
    // start blocks acceptance so it can never race with a new descriptor
    assign in_ready = ~reset & ~start & ~full & (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept) state_d = enc_illegal ? ST_ERR : ST_WRITE;
                ST_WRITE: if (mem_ready) state_d = ST_IDLE;
                ST_ERR:   state_d = ST_ERR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        if (start) begin
            addr_d  = base_addr;
            count_d = '0;
        end else if ((state_q == ST_IDLE) && accept && !enc_illegal) begin
            wdata_d = enc_word;
        end else if ((state_q == ST_WRITE) && mem_ready) begin
            addr_d  = addr_q + 32'd4;
            count_d = count_q + 16'd1;
        end
    end

    always_comb begin
        mem_we     = (state_q == ST_WRITE);
        err        = (state_q == ST_ERR);
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        word_count = count_q;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_s, in_use_imm, mem_ready;
    logic [31:0] base_addr, in_imm;
    logic [3:0]  in_class, in_cond, in_rd, in_ra, in_rn, in_rm;
    logic        in_ready, mem_we, full, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [15:0] word_count;
    logic        s_in_ready, s_mem_we, s_full, s_err;
    logic [31:0] s_mem_addr, s_mem_wdata;
    logic [15:0] s_word_count;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_addr;
    int          exp_count;

    typedef struct {
        int          cls;
        logic [3:0]  cond;
        logic        s;
        logic        use_imm;
        logic [3:0]  rd, ra, rn, rm;
        logic [31:0] imm;
    } desc_t;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_cond(in_cond),
        .in_s(in_s), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_ra(in_ra), .in_rn(in_rn),
        .in_rm(in_rm), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .word_count(word_count),
        .full(full), .err(err)
    );

    instr_encoder #(.MAX_WORDS(2)) u_dut_small (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_class(in_class), .in_cond(in_cond),
        .in_s(in_s), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_ra(in_ra), .in_rn(in_rn),
        .in_rm(in_rm), .in_imm(in_imm), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_ready(mem_ready), .word_count(s_word_count),
        .full(s_full), .err(s_err)
    );

    // Reference: instruction word built from field positions with plain arithmetic
    function automatic void ref_encode(input desc_t d, output logic [31:0] w, output bit bad);
        int          cmd_tab[6] = '{4, 2, 0, 12, 9, 1};
        logic [63:0] acc;
        bit          imm_on;
        int          off;
        bad = 1'b0;
        acc = 64'(d.cond) << 28;
        if (d.cls >= 0 && d.cls <= 5) begin
            imm_on = d.use_imm && (d.cls < 4);
            bad    = imm_on && (d.imm > 32'd255);
            acc    = acc + (64'(imm_on) << 25) + (64'(cmd_tab[d.cls]) << 21) + (64'(d.s) << 20)
                   + (64'(d.rn) << 16) + (64'(d.rd) << 12)
                   + (imm_on ? 64'(d.imm % 32'd256) : 64'(d.rm));
        end else if (d.cls == 6 || d.cls == 7) begin
            bad = d.imm > 32'd4095;
            acc = acc + (64'd1 << 26) + (64'd1 << 24) + (64'd1 << 23) + (64'(d.cls == 6) << 20)
                + (64'(d.rn) << 16) + (64'(d.rd) << 12) + 64'(d.imm % 32'd4096);
        end else if (d.cls == 8) begin
            off = int'($signed(d.imm));
            bad = (off < -8388608) || (off > 8388607);
            acc = acc + (64'd10 << 24) + 64'(d.imm % 32'h0100_0000);
        end else if (d.cls == 9 || d.cls == 10) begin
            acc = acc + (64'd1 << 23) + (64'(d.cls == 9) << 22) + (64'(d.s) << 20)
                + (64'(d.ra) << 16) + (64'(d.rd) << 12) + (64'(d.rm) << 8) + (64'd9 << 4)
                + 64'(d.rn);
        end else begin
            bad = 1'b1;
            acc = 64'd0;
        end
        w = acc[31:0];
    endfunction

    function automatic desc_t mk(input int cls, input logic [3:0] cond, input logic s,
                                 input logic use_imm, input logic [3:0] rd, input logic [3:0] ra,
                                 input logic [3:0] rn, input logic [3:0] rm, input logic [31:0] imm);
        desc_t d;
        d.cls = cls; d.cond = cond; d.s = s; d.use_imm = use_imm;
        d.rd = rd; d.ra = ra; d.rn = rn; d.rm = rm; d.imm = imm;
        return d;
    endfunction

    function automatic desc_t rand_desc();
        desc_t d;
        d.cls     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10));
        d.cond    = 4'($urandom_range(0, 15));
        d.s       = 1'($urandom_range(0, 1));
        d.use_imm = 1'($urandom_range(0, 1));
        d.rd      = 4'($urandom_range(0, 15));
        d.ra      = 4'($urandom_range(0, 15));
        d.rn      = 4'($urandom_range(0, 15));
        d.rm      = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0:       d.imm = $urandom_range(0, 255);
            1:       d.imm = $urandom_range(0, 4095);
            2:       d.imm = $urandom();
            default: d.imm = $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000;
        endcase
        return d;
    endfunction

    task automatic drive_desc(input desc_t d);
        in_class = 4'(d.cls); in_cond = d.cond; in_s = d.s; in_use_imm = d.use_imm;
        in_rd = d.rd; in_ra = d.ra; in_rn = d.rn; in_rm = d.rm; in_imm = d.imm;
    endtask

    task automatic do_start(input logic [31:0] base);
        start = 1'b1; base_addr = base;
        @(negedge clk);
        start = 1'b0;
        exp_addr = base; exp_count = 0;
    endtask

    // Offer a descriptor until u_dut takes it; returns at the negedge after acceptance
    task automatic accept(input desc_t d, output bit ok);
        drive_desc(d);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_write(input int stall);
        for (int i = 0; i < stall; i++) @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        exp_addr  = exp_addr + 32'd4;
        exp_count = exp_count + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b1; mem_ready = 1'b0;
        drive_desc(mk(0, 4'hE, 1'b0, 1'b0, 4'h1, 4'h0, 4'h2, 4'h3, 32'd0));
        @(negedge clk); @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b want 0", in_ready); else passes++;
        checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got %0b want 0", mem_we); else passes++;
        checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else passes++;
        checks++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); else passes++;
        checks++; if (word_count !== 16'd0) $display("FAIL rst_word_count got %0d want 0", word_count); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL rst_err got %0b want 0", err); else passes++;
        checks++; if (full !== 1'b0) $display("FAIL rst_full got %0b want 0", full); else passes++;
        in_valid = 1'b0; reset = 1'b0;
        @(negedge clk); #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %0b want 1", in_ready); else passes++;
        exp_addr = 32'h0; exp_count = 0;
    endtask

    task automatic test_directed();
        desc_t       ds[6];
        logic [31:0] ws[6];
        bit          ok;
        ds[0] = mk(0,  4'hE, 1'b0, 1'b1, 4'd1, 4'd0, 4'd2, 4'd0, 32'd5);        ws[0] = 32'hE2821005;
        ds[1] = mk(6,  4'hE, 1'b0, 1'b0, 4'd3, 4'd0, 4'd4, 4'd0, 32'd8);        ws[1] = 32'hE5943008;
        ds[2] = mk(7,  4'hE, 1'b0, 1'b0, 4'd3, 4'd0, 4'd4, 4'd0, 32'd8);        ws[2] = 32'hE5843008;
        ds[3] = mk(8,  4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFE); ws[3] = 32'hEAFFFFFE;
        ds[4] = mk(9,  4'hE, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 32'd0);        ws[4] = 32'hE0C10392;
        ds[5] = mk(10, 4'hE, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 4'd3, 32'd0);        ws[5] = 32'hE0810392;
        do_start(32'h100);
        for (int i = 0; i < 6; i++) begin
            accept(ds[i], ok);
            checks++; if (!ok) $display("FAIL dir%0d_accept timeout", i); else passes++;
            checks++; if (mem_we !== 1'b1) $display("FAIL dir%0d_we got %0b want 1", i, mem_we); else passes++;
            checks++; if (mem_addr !== 32'h100 + 32'(4 * i)) $display("FAIL dir%0d_addr got %h want %h", i, mem_addr, 32'h100 + 32'(4 * i)); else passes++;
            checks++; if (mem_wdata !== ws[i]) $display("FAIL dir%0d_wdata got %h want %h", i, mem_wdata, ws[i]); else passes++;
            finish_write(0);
            checks++; if (word_count !== 16'(i + 1)) $display("FAIL dir%0d_count got %0d want %0d", i, word_count, i + 1); else passes++;
        end
    endtask

    task automatic test_stall();
        desc_t       d;
        logic [31:0] w;
        bit          bad, ok;
        do_start(32'h2000);
        d = mk(3, 4'h1, 1'b1, 1'b0, 4'd7, 4'd0, 4'd8, 4'd9, 32'd0);
        ref_encode(d, w, bad);
        accept(d, ok);
        checks++; if (!ok) $display("FAIL stall_accept timeout"); else passes++;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (mem_we !== 1'b1) $display("FAIL stall%0d_we got %0b want 1", i, mem_we); else passes++;
            checks++; if (mem_wdata !== w) $display("FAIL stall%0d_wdata got %h want %h", i, mem_wdata, w); else passes++;
            checks++; if (mem_addr !== 32'h2000) $display("FAIL stall%0d_addr got %h want 2000", i, mem_addr); else passes++;
            checks++; if (in_ready !== 1'b0) $display("FAIL stall%0d_in_ready got %0b want 0", i, in_ready); else passes++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        finish_write(0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (word_count !== 16'd1) $display("FAIL stall_count%0d got %0d want 1", i, word_count); else passes++;
            checks++; if (mem_we !== 1'b0) $display("FAIL stall_we_after%0d got %0b want 0", i, mem_we); else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_error();
        bit ok;
        do_start(32'h300);
        accept(mk(0, 4'hE, 1'b0, 1'b1, 4'd1, 4'd0, 4'd2, 4'd0, 32'd256), ok);
        checks++; if (!ok) $display("FAIL err_accept timeout"); else passes++;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (err !== 1'b1) $display("FAIL err%0d_err got %0b want 1", i, err); else passes++;
            checks++; if (mem_we !== 1'b0) $display("FAIL err%0d_we got %0b want 0", i, mem_we); else passes++;
            checks++; if (in_ready !== 1'b0) $display("FAIL err%0d_in_ready got %0b want 0", i, in_ready); else passes++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (word_count !== 16'd0) $display("FAIL err_count got %0d want 0", word_count); else passes++;
        do_start(32'h300);
        #1;
        checks++; if (err !== 1'b0) $display("FAIL err_clear got %0b want 0", err); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL err_clear_in_ready got %0b want 1", in_ready); else passes++;
    endtask

    task automatic test_boundaries();
        desc_t       ds[10];
        logic [31:0] w;
        bit          bad, ok;
        ds[0] = mk(0,  4'h0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd2, 4'd3, 32'd255);
        ds[1] = mk(1,  4'h0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd2, 4'd3, 32'd256);
        ds[2] = mk(4,  4'h0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd2, 4'd3, 32'd256);
        ds[3] = mk(6,  4'h0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 4'd3, 32'd4095);
        ds[4] = mk(7,  4'h0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 4'd3, 32'd4096);
        ds[5] = mk(8,  4'h0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 4'd3, 32'h007F_FFFF);
        ds[6] = mk(8,  4'h0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 4'd3, 32'h0080_0000);
        ds[7] = mk(8,  4'h0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 4'd3, 32'hFF80_0000);
        ds[8] = mk(8,  4'h0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 4'd3, 32'hFF7F_FFFF);
        ds[9] = mk(12, 4'h0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 4'd3, 32'd0);
        for (int i = 0; i < 10; i++) begin
            ref_encode(ds[i], w, bad);
            do_start(32'h400);
            accept(ds[i], ok);
            checks++; if (!ok) $display("FAIL bnd%0d_accept timeout", i); else passes++;
            checks++; if (err !== bad) $display("FAIL bnd%0d_err got %0b want %0b", i, err, bad); else passes++;
            checks++; if (mem_we !== !bad) $display("FAIL bnd%0d_we got %0b want %0b", i, mem_we, !bad); else passes++;
            if (!bad) begin
                checks++; if (mem_wdata !== w) $display("FAIL bnd%0d_wdata got %h want %h", i, mem_wdata, w); else passes++;
                finish_write(0);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_start(32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) begin
            accept(mk(0, 4'hE, 1'b0, 1'b1, 4'd1, 4'd0, 4'd2, 4'd0, 32'(i)), ok);
            checks++; if (mem_addr !== exp_addr) $display("FAIL wrap%0d_addr got %h want %h", i, mem_addr, exp_addr); else passes++;
            finish_write(0);
        end
        checks++; if (mem_addr !== 32'h4) $display("FAIL wrap_final_addr got %h want 4", mem_addr); else passes++;
    endtask

    task automatic test_full();
        bit          ok;
        desc_t       d;
        logic [31:0] w;
        bit          bad;
        d = mk(2, 4'h3, 1'b0, 1'b0, 4'd5, 4'd0, 4'd6, 4'd7, 32'd0);
        ref_encode(d, w, bad);
        do_start(32'h500);
        for (int i = 0; i < 2; i++) begin
            accept(d, ok);
            checks++; if (!ok) $display("FAIL full%0d_accept timeout", i); else passes++;
            finish_write(1);
        end
        #1;
        checks++; if (s_full !== 1'b1) $display("FAIL full_flag got %0b want 1", s_full); else passes++;
        checks++; if (s_in_ready !== 1'b0) $display("FAIL full_in_ready got %0b want 0", s_in_ready); else passes++;
        checks++; if (s_word_count !== 16'd2) $display("FAIL full_count got %0d want 2", s_word_count); else passes++;
        checks++; if (full !== 1'b0) $display("FAIL big_not_full got %0b want 0", full); else passes++;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (s_mem_we !== 1'b0) $display("FAIL full_no_write%0d got %0b want 0", i, s_mem_we); else passes++;
        end
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1) $display("FAIL big_pending_we got %0b want 1", mem_we); else passes++;
        do_start(32'h600);
        checks++; if (mem_we !== 1'b0) $display("FAIL big_abort_we got %0b want 0", mem_we); else passes++;
        checks++; if (word_count !== 16'd0) $display("FAIL big_abort_count got %0d want 0", word_count); else passes++;
        checks++; if (s_full !== 1'b0) $display("FAIL full_cleared got %0b want 0", s_full); else passes++;
        accept(d, ok);
        checks++; if (s_mem_we !== 1'b1) $display("FAIL small_we got %0b want 1", s_mem_we); else passes++;
        checks++; if (s_mem_wdata !== w) $display("FAIL small_wdata got %h want %h", s_mem_wdata, w); else passes++;
        do_start(32'h700);
        checks++; if (s_mem_we !== 1'b0) $display("FAIL small_abort_we got %0b want 0", s_mem_we); else passes++;
        checks++; if (s_word_count !== 16'd0) $display("FAIL small_abort_count got %0d want 0", s_word_count); else passes++;
        checks++; if (s_mem_addr !== 32'h700) $display("FAIL small_abort_addr got %h want 700", s_mem_addr); else passes++;
        mem_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        mem_ready = 1'b0;
        checks++; if (s_word_count !== 16'd0) $display("FAIL small_discard_count got %0d want 0", s_word_count); else passes++;
        checks++; if (s_err !== 1'b0) $display("FAIL small_err got %0b want 0", s_err); else passes++;
    endtask

    task automatic test_random();
        desc_t       d;
        logic [31:0] w;
        bit          bad, ok;
        do_start({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        for (int n = 0; n < 150; n++) begin
            d = rand_desc();
            ref_encode(d, w, bad);
            accept(d, ok);
            checks++; if (!ok) $display("FAIL rnd%0d_accept timeout", n); else passes++;
            checks++; if (err !== bad) $display("FAIL rnd%0d_err got %0b want %0b cls %0d imm %h", n, err, bad, d.cls, d.imm); else passes++;
            checks++; if (mem_we !== !bad) $display("FAIL rnd%0d_we got %0b want %0b", n, mem_we, !bad); else passes++;
            if (bad) begin
                do_start({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            end else begin
                checks++; if (mem_wdata !== w) $display("FAIL rnd%0d_wdata got %h want %h cls %0d", n, mem_wdata, w, d.cls); else passes++;
                checks++; if (mem_addr !== exp_addr) $display("FAIL rnd%0d_addr got %h want %h", n, mem_addr, exp_addr); else passes++;
                if ($urandom_range(0, 15) == 0) begin
                    do_start({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
                    checks++; if (mem_we !== 1'b0) $display("FAIL rnd%0d_abort_we got %0b want 0", n, mem_we); else passes++;
                end else begin
                    finish_write(int'($urandom_range(0, 3)));
                    checks++; if (mem_we !== 1'b0) $display("FAIL rnd%0d_we_done got %0b want 0", n, mem_we); else passes++;
                end
                checks++; if (word_count !== 16'(exp_count)) $display("FAIL rnd%0d_count got %0d want %0d", n, word_count, exp_count); else passes++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_error();
        test_boundaries();
        test_wrap();
        test_full();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
